// File: rtl/vx_cache_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vx_cache_types_pkg
//  Brief    : Shared cache types and constants for the dirty-line writeback
//             queue (address width, default geometry, entry type, width
//             helpers).
//  Revision : 1.0 - initial release
// ============================================================================
package vx_cache_types_pkg;

  // Line address width {readtag, line index}
  localparam int LINE_ADDR_WIDTH = 28;

  // Default bank geometry
  localparam int BANK_LINE_SIZE_DEF  = 16;
  localparam int BANK_LINE_WIDTH_DEF = BANK_LINE_SIZE_DEF * 8;
  localparam int DWBQ_SIZE_DEF       = 4;

  // Pointer / occupancy widths for a queue of n entries
  function automatic int dwbq_ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int dwbq_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DWBQ_PTR_W = dwbq_ptr_w(DWBQ_SIZE_DEF);
  localparam int DWBQ_CNT_W = dwbq_cnt_w(DWBQ_SIZE_DEF);

  // One queued writeback at the default line size
  typedef struct packed {
    logic [LINE_ADDR_WIDTH-1:0]     addr;
    logic [BANK_LINE_WIDTH_DEF-1:0] data;
    logic [BANK_LINE_SIZE_DEF-1:0]  byteen;
  } dwbq_entry_t;

endpackage
`default_nettype wire

// File: rtl/vx_dwbq_match.sv
`default_nettype none
// ============================================================================
//  Module   : vx_dwbq_match
//  Brief    : N-way line-address comparator. One match bit per valid entry
//             whose address equals the probe, with an exclusion mask so the
//             merge path can ignore the entry currently being issued.
//  Revision : 1.0 - initial release
// ============================================================================
module vx_dwbq_match #(
  parameter int N  = 4,
  parameter int AW = 28
) (
  input  logic [N-1:0]         entry_valid,
  input  logic [N-1:0][AW-1:0] entry_addr,
  input  logic [AW-1:0]        probe_addr,
  input  logic [N-1:0]         exclude_mask,
  output logic [N-1:0]         match
);

  // One comparator per entry
  for (genvar i = 0; i < N; i++) begin : g_way
    assign match[i] = entry_valid[i] && !exclude_mask[i] && (entry_addr[i] == probe_addr);
  end

endmodule
`default_nettype wire

// File: rtl/vx_writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module   : vx_writeback_queue
//  Brief    : Per-bank dirty-line writeback FIFO. Captures dirty victims from
//             stage 1, issues them as DRAM writes over valid/ready, exposes
//             fill-level back-pressure and a pending-address lookup.
//  Options  : DWBQ_MERGE_EN - merge a push into a matching non-head entry.
//  Revision : 1.0 - initial release
// ============================================================================
module vx_writeback_queue
  import vx_cache_types_pkg::*;
#(
  parameter int CACHE_ID       = 0,
  parameter int BANK_ID        = 0,
  parameter int BANK_LINE_SIZE = 16,
  parameter int DWBQ_SIZE      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_valid,
  input  logic [LINE_ADDR_WIDTH-1:0]   push_addr,
  input  logic [BANK_LINE_SIZE*8-1:0]  push_data,
  input  logic [BANK_LINE_SIZE-1:0]    push_byteen,
  output logic                         full,
  output logic                         almost_full,
  input  logic [LINE_ADDR_WIDTH-1:0]   lookup_addr,
  output logic                         lookup_hit,
  output logic                         dram_req_valid,
  output logic [LINE_ADDR_WIDTH-1:0]   dram_req_addr,
  output logic [BANK_LINE_SIZE*8-1:0]  dram_req_data,
  output logic [BANK_LINE_SIZE-1:0]    dram_req_byteen,
  input  logic                         dram_req_ready,
  output logic                         overflow_err
);

  localparam int BANK_LINE_WIDTH = BANK_LINE_SIZE * 8;
  localparam int PTR_W           = dwbq_ptr_w(DWBQ_SIZE);
  localparam int CNT_W           = dwbq_cnt_w(DWBQ_SIZE);

  // Elaboration-time sanity checks on configuration
  if (DWBQ_SIZE < 2 || (DWBQ_SIZE & (DWBQ_SIZE - 1)) != 0) begin : g_bad_size
    $error("vx_writeback_queue: DWBQ_SIZE must be a power of two >= 2");
  end
  if (CACHE_ID < 0 || BANK_ID < 0) begin : g_bad_id
    $error("vx_writeback_queue: CACHE_ID/BANK_ID must be non-negative");
  end

  typedef struct packed {
    logic [LINE_ADDR_WIDTH-1:0] addr;
    logic [BANK_LINE_WIDTH-1:0] data;
    logic [BANK_LINE_SIZE-1:0]  byteen;
  } entry_t;

  entry_t [DWBQ_SIZE-1:0] entry_q, entry_d;
  logic   [DWBQ_SIZE-1:0] valid_q, valid_d;
  logic   [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic   [CNT_W-1:0]     count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic [DWBQ_SIZE-1:0][LINE_ADDR_WIDTH-1:0] entry_addr;
  logic [DWBQ_SIZE-1:0] lookup_match;
  logic [DWBQ_SIZE-1:0] merge_match;
  logic                 merge_hit;
  logic                 push_alloc;
  logic                 pop;

  // Address view of storage for the comparators
  always_comb begin
    for (int i = 0; i < DWBQ_SIZE; i++) begin
      entry_addr[i] = entry_q[i].addr;
    end
  end

  assign full            = (count_q == CNT_W'(DWBQ_SIZE));
  assign almost_full     = (count_q >= CNT_W'(DWBQ_SIZE - 1));
  assign dram_req_valid  = valid_q[head_q];
  assign dram_req_addr   = entry_q[head_q].addr;
  assign dram_req_data   = entry_q[head_q].data;
  assign dram_req_byteen = entry_q[head_q].byteen;
  assign overflow_err    = overflow_q;

  vx_dwbq_match #(.N(DWBQ_SIZE), .AW(LINE_ADDR_WIDTH)) u_lookup_match (
    .entry_valid  (valid_q),
    .entry_addr   (entry_addr),
    .probe_addr   (lookup_addr),
    .exclude_mask ({DWBQ_SIZE{1'b0}}),
    .match        (lookup_match)
  );
  assign lookup_hit = |lookup_match;

`ifdef DWBQ_MERGE_EN
  // The entry being presented to DRAM must stay stable, so it never merges
  logic [DWBQ_SIZE-1:0] head_mask;
  assign head_mask = dram_req_valid ? (DWBQ_SIZE'(1) << head_q) : {DWBQ_SIZE{1'b0}};

  vx_dwbq_match #(.N(DWBQ_SIZE), .AW(LINE_ADDR_WIDTH)) u_merge_match (
    .entry_valid  (valid_q),
    .entry_addr   (entry_addr),
    .probe_addr   (push_addr),
    .exclude_mask (head_mask),
    .match        (merge_match)
  );
`else
  assign merge_match = {DWBQ_SIZE{1'b0}};
`endif

  assign merge_hit  = push_valid && (|merge_match);
  assign push_alloc = push_valid && !merge_hit && !full;
  assign pop        = dram_req_valid && dram_req_ready;

  // Next-state: pop at head, allocate at tail, merge into a matching entry
  always_comb begin
    entry_d    = entry_q;
    valid_d    = valid_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end

    if (push_alloc) begin
      entry_d[tail_q].addr   = push_addr;
      entry_d[tail_q].data   = push_data;
      entry_d[tail_q].byteen = push_byteen;
      valid_d[tail_q]        = 1'b1;
      tail_d                 = tail_q + PTR_W'(1);
    end

    if (push_valid) begin
      for (int i = 0; i < DWBQ_SIZE; i++) begin
        if (merge_match[i]) begin
          for (int b = 0; b < BANK_LINE_SIZE; b++) begin
            if (push_byteen[b]) begin
              entry_d[i].data[b*8 +: 8] = push_data[b*8 +: 8];
            end
          end
          entry_d[i].byteen = entry_q[i].byteen | push_byteen;
        end
      end
    end

    if (push_alloc && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_alloc && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    // A refused push means the bank ignored almost_full
    if (push_valid && full && !merge_hit) begin
      overflow_d = 1'b1;
    end
  end

  // Control state register, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage; contents are don't-care until marked valid
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_vx_writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vx_writeback_queue
//  Brief    : Directed self-checking bench for vx_writeback_queue.
//  Options  : DWBQ_MERGE_EN - selects the merge or duplicate-allocate steps.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vx_writeback_queue;
  import vx_cache_types_pkg::*;

  logic                           clk = 1'b0;
  logic                           reset;
  logic                           push_valid;
  logic [LINE_ADDR_WIDTH-1:0]     push_addr;
  logic [BANK_LINE_WIDTH_DEF-1:0] push_data;
  logic [BANK_LINE_SIZE_DEF-1:0]  push_byteen;
  logic                           full;
  logic                           almost_full;
  logic [LINE_ADDR_WIDTH-1:0]     lookup_addr;
  logic                           lookup_hit;
  logic                           dram_req_valid;
  logic [LINE_ADDR_WIDTH-1:0]     dram_req_addr;
  logic [BANK_LINE_WIDTH_DEF-1:0] dram_req_data;
  logic [BANK_LINE_SIZE_DEF-1:0]  dram_req_byteen;
  logic                           dram_req_ready;
  logic                           overflow_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vx_writeback_queue #(
    .CACHE_ID       (0),
    .BANK_ID        (0),
    .BANK_LINE_SIZE (BANK_LINE_SIZE_DEF),
    .DWBQ_SIZE      (DWBQ_SIZE_DEF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .push_valid      (push_valid),
    .push_addr       (push_addr),
    .push_data       (push_data),
    .push_byteen     (push_byteen),
    .full            (full),
    .almost_full     (almost_full),
    .lookup_addr     (lookup_addr),
    .lookup_hit      (lookup_hit),
    .dram_req_valid  (dram_req_valid),
    .dram_req_addr   (dram_req_addr),
    .dram_req_data   (dram_req_data),
    .dram_req_byteen (dram_req_byteen),
    .dram_req_ready  (dram_req_ready),
    .overflow_err    (overflow_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [27:0] a, input logic [15:0] be, input logic [127:0] d);
    push_valid  = 1'b1;
    push_addr   = a;
    push_byteen = be;
    push_data   = d;
  endtask

  task automatic probe(input string tag, input logic [27:0] a, input logic exp);
    lookup_addr = a;
    #1;
    chk(tag, lookup_hit, exp);
  endtask

  logic [127:0] d_a;
  logic [127:0] d_b;

  initial begin
    reset          = 1'b0;
    push_valid     = 1'b0;
    push_addr      = '0;
    push_data      = '0;
    push_byteen    = '0;
    lookup_addr    = '0;
    dram_req_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_full", full, 1'b0);
    chk("rst_afull", almost_full, 1'b0);
    chk("rst_valid", dram_req_valid, 1'b0);
    chk("rst_ovf", overflow_err, 1'b0);
    chk("rst_hit", lookup_hit, 1'b0);
    chk("rst_count", dut.count_q, 3'd0);
    reset = 1'b1;
    tick();

    // Single push with ready high: presented next cycle, then popped
    dram_req_ready = 1'b1;
    d_a = {4{32'hCAFE_001A}};
    set_push(28'h1A, 16'hFFFF, d_a);
    tick();
    push_valid = 1'b0;
    chk("one_valid", dram_req_valid, 1'b1);
    chk("one_addr", dram_req_addr, 28'h1A);
    chk("one_byteen", dram_req_byteen, 16'hFFFF);
    chk("one_data", dram_req_data, d_a);
    tick();
    chk("one_popped_valid", dram_req_valid, 1'b0);
    chk("one_popped_count", dut.count_q, 3'd0);

    // Fill four entries under stall
    dram_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_push(28'h100 + 28'(k), 16'hFFFF, {4{32'hD000_0000 + 32'(k)}});
      tick();
      if (k == 0) chk("fill1_afull", almost_full, 1'b0);
      if (k == 1) chk("fill2_afull", almost_full, 1'b0);
      if (k == 2) begin
        chk("fill3_afull", almost_full, 1'b1);
        chk("fill3_full", full, 1'b0);
      end
      if (k == 3) chk("fill4_full", full, 1'b1);
    end
    push_valid = 1'b0;
    probe("lk_second", 28'h101, 1'b1);
    probe("lk_head", 28'h100, 1'b1);
    probe("lk_popped", 28'h1A, 1'b0);

    // Fifth push while full is dropped
    set_push(28'h104, 16'hFFFF, {4{32'hDEAD_0104}});
    tick();
    push_valid = 1'b0;
    chk("ovf_set", overflow_err, 1'b1);
    chk("ovf_head_addr", dram_req_addr, 28'h100);
    chk("ovf_head_data", dram_req_data, {4{32'hD000_0000}});
    chk("ovf_count", dut.count_q, 3'd4);
    probe("lk_dropped", 28'h104, 1'b0);

    // Full with simultaneous pop and push: pop only
    dram_req_ready = 1'b1;
    set_push(28'h105, 16'hFFFF, {4{32'hDEAD_0105}});
    tick();
    push_valid     = 1'b0;
    dram_req_ready = 1'b0;
    chk("pp_count", dut.count_q, 3'd3);
    chk("pp_ovf", overflow_err, 1'b1);
    chk("pp_full", full, 1'b0);
    chk("pp_afull", almost_full, 1'b1);
    chk("pp_head", dram_req_addr, 28'h101);
    probe("lk_refused", 28'h105, 1'b0);
    probe("lk_gone", 28'h100, 1'b0);

    // Back-to-back drain, one line per cycle
    dram_req_ready = 1'b1;
    tick();
    chk("drain_head2", dram_req_addr, 28'h102);
    tick();
    chk("drain_head3", dram_req_addr, 28'h103);
    chk("drain_data3", dram_req_data, {4{32'hD000_0003}});
    tick();
    chk("drain_empty", dram_req_valid, 1'b0);
    chk("drain_count", dut.count_q, 3'd0);

    // All-zero byte mask still allocates and forwards unchanged
    dram_req_ready = 1'b0;
    set_push(28'h40, 16'h0000, {4{32'h0000_0040}});
    tick();
    push_valid = 1'b0;
    chk("zbe_valid", dram_req_valid, 1'b1);
    chk("zbe_byteen", dram_req_byteen, 16'h0000);
    dram_req_ready = 1'b1;
    tick();
    dram_req_ready = 1'b0;
    chk("zbe_popped", dram_req_valid, 1'b0);

`ifdef DWBQ_MERGE_EN
    // Merge into a non-head entry
    d_a = {4{32'h1111_1111}};
    d_b = {4{32'h2222_2222}};
    set_push(28'h30, 16'hFFFF, {4{32'h3030_3030}});
    tick();
    set_push(28'h20, 16'h000F, d_a);
    tick();
    set_push(28'h20, 16'h00F0, d_b);
    tick();
    push_valid = 1'b0;
    chk("mrg_count", dut.count_q, 3'd2);
    dram_req_ready = 1'b1;
    tick();
    dram_req_ready = 1'b0;
    chk("mrg_addr", dram_req_addr, 28'h20);
    chk("mrg_byteen", dram_req_byteen, 16'h00FF);
    chk("mrg_data", dram_req_data, 128'h11111111_11111111_22222222_11111111);
    dram_req_ready = 1'b1;
    tick();
    dram_req_ready = 1'b0;
    chk("mrg_empty", dut.count_q, 3'd0);
`else
    // Duplicates of the same address coexist
    set_push(28'h50, 16'h000F, {4{32'h5050_5050}});
    tick();
    set_push(28'h50, 16'h00F0, {4{32'h5151_5151}});
    tick();
    push_valid = 1'b0;
    chk("dup_count", dut.count_q, 3'd2);
    chk("dup_head_byteen", dram_req_byteen, 16'h000F);
    dram_req_ready = 1'b1;
    tick();
    chk("dup_second_byteen", dram_req_byteen, 16'h00F0);
    chk("dup_second_addr", dram_req_addr, 28'h50);
    tick();
    dram_req_ready = 1'b0;
    chk("dup_empty", dut.count_q, 3'd0);
`endif

    // Reset mid-stall with two pending entries
    set_push(28'h200, 16'hFFFF, {4{32'h0000_0200}});
    tick();
    set_push(28'h201, 16'hFFFF, {4{32'h0000_0201}});
    tick();
    push_valid = 1'b0;
    chk("mid_count", dut.count_q, 3'd2);
    chk("mid_valid", dram_req_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", dram_req_valid, 1'b0);
    chk("arst_ovf", overflow_err, 1'b0);
    chk("arst_afull", almost_full, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_count", dut.count_q, 3'd0);
    chk("post_rst_valid", dram_req_valid, 1'b0);
    probe("post_rst_lk", 28'h201, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
